vertex_transform_unit: RTL and testbench
========================================

# vertex_transform_unit

Parametrised successor to the single-matrix vertex shader. It transforms a stream of 3-component fixed-point vertices by one of NUM_MATS stored 4x4 matrices, selected per vertex, into homogeneous 4-component clip-space vertices. It has a self-contained fixed-latency multiply-accumulate pipeline, full valid/ready backpressure on both sides via an output FIFO with credit gating, saturating arithmetic, and batch status. It sits between the vertex fetch stage and primitive assembly in the render pipeline.

## Interface
- DATAWIDTH, 24: signed fixed-point word width.
- FRACBITS, 13: fractional bits; fixed-point one = 1<<FRACBITS.
- NUM_MATS, 4: matrix bank entries, ≥1; MIDX_W = max(1, $clog2(NUM_MATS)).
- FIFO_DEPTH, 8: output FIFO entries, ≥4.
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous and active-low.
- i_mat_wr  in  1  write i_mat into bank entry i_mat_idx.
- i_mat_idx  in  MIDX_W  bank entry to write.
- i_mat  in  DATAWIDTH×[4][4]  signed matrix, row-major.
- i_start  in  1  begin a batch.
- o_busy  out  1  high in RUN or DRAIN.
- o_finished  out  1  one-cycle pulse at batch end.
- i_vertex  in  DATAWIDTH×[3]  signed x,y,z.
- i_vertex_midx  in  MIDX_W  matrix selector for this vertex.
- i_vertex_valid  in  1  input valid.
- i_vertex_last  in  1  marks the final vertex of the batch.
- o_vertex_ready  out  1  input ready.
- o_vertex  out  DATAWIDTH×[4]  signed x,y,z,w.
- o_vertex_valid  out  1  output valid.
- o_vertex_last  out  1  marks the last output of the batch.
- i_vertex_ready  in  1  downstream ready.
- o_count  out  16  vertices accepted in the current batch; wraps at 65535→0.
- o_sat  out  1  sticky flag: any component saturated this batch.

## Operation
- **States:**
  - IDLE→RUN on i_start.
  - RUN→DRAIN on the handshake where i_vertex_last=1.
  - DRAIN→DONE when the pipeline and FIFO are empty.
  - DONE→IDLE unconditionally after one cycle; o_finished=1 only in DONE.
  - i_start is ignored outside IDLE.
- **Matrix writes:** accepted only in IDLE; ignored in any other state. Unwritten entries hold zero. An out-of-range i_mat_idx (≥NUM_MATS) write is ignored. An out-of-range i_vertex_midx uses entry 0.
- **Accept condition:** a vertex is accepted when i_vertex_valid & o_vertex_ready.
  - o_vertex_ready = (state==RUN) & (fifo_count + inflight < FIFO_DEPTH), where inflight counts vertices in the 3 pipeline stages.
  - There is no stall inside the pipeline; credit gating guarantees a FIFO slot.
- **Input extension:** w_in = fixed-point one.
- **Arithmetic:**
  - y[r] = Σ_c M[r][c]·v[c], using full 2·DATAWIDTH products and 2 guard bits on the sum.
  - The sum is arithmetic-shifted right by FRACBITS (floor), then saturated to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1].
  - Any clamp sets o_sat.
- **Pipeline stages:** S1 registers the 16 products; S2 registers the 4 row sums; S3 performs shift/saturate and writes the FIFO.
- **last tag:** travels with its vertex to o_vertex_last.
- **Output FIFO:** first-word-fall-through. An entry pops on o_vertex_valid & i_vertex_ready. o_vertex and o_vertex_last are held stable while valid is high and not accepted.
- **Batch status:** o_count and o_sat clear on i_start in IDLE. o_count increments per accepted vertex.

## Timing
- **Reset values:**
  - State IDLE, bank zeroed, FIFO empty, pipeline valid bits cleared.
  - o_busy=0, o_finished=0, o_vertex_ready=0, o_vertex_valid=0, o_vertex_last=0, o_vertex=0, o_count=0, o_sat=0.
- **Latency:** with the FIFO empty, acceptance at edge k gives o_vertex_valid=1 during the cycle after edge k+3.
- **Throughput:** 1 vertex/cycle sustained when downstream ready is held high.
- **Simultaneous push/pop on a full-credit FIFO:** fifo_count is unchanged and ready remains asserted.
- **o_vertex_ready:** combinational from registered state/counters only; never from i_vertex_valid.
- **Mid-batch reset:** rstn low mid-batch asynchronously discards all in-flight and queued vertices and returns to IDLE. The matrix bank is cleared.
- **i_vertex_last and FIFO fill:** i_vertex_last on the first vertex gives a one-vertex batch. The FIFO may fill while in DRAIN; DONE waits for downstream to empty it.

## Test plan
- **Identity:** bank[0]=identity, vertex (1.0,2.0,3.0)=(8192,16384,24576) -> output (8192,16384,24576,8192), valid exactly 4 cycles after the handshake edge, o_sat=0.
- **Per-vertex select:** bank[1]=translate(+1.0,−2.0,0); vertices alternate midx 0/1 on (0,0,0) -> outputs alternate (0,0,0,8192) and (8192,−16384,0,8192).
- **Saturation:** bank[2]=diag(512.0,512.0,512.0,1.0), vertex (4.0,−4.0,0) -> (8388607,−8388608,0,8192), o_sat=1 until the next i_start.
- **Backpressure:** stream 20 vertices with i_vertex_ready toggling randomly; o_vertex_ready drops when fifo+inflight=8. Expect all 20 outputs in order, none lost or duplicated, o_vertex_last only on the 20th, o_count=20, and o_finished one cycle after the FIFO empties.
- **Illegal writes/starts:** i_mat_wr and i_start pulsed during RUN -> bank unchanged, batch unaffected.
- **Mid-batch reset:** assert rstn=0 with 3 vertices in flight -> all outputs 0 immediately; after release the unit is in IDLE with an empty FIFO.

Source files
------------

// File: rtl/vertex_transform_unit.sv
// Vertex transform: 4x4 matrix bank times (x,y,z,1) with saturation.
// Three-stage MAC pipeline feeding a credit-gated FWFT output FIFO.
//
// Ports:
//   clk, rstn              clock, async active-low reset
//   i_mat_wr/idx/mat       matrix bank write (IDLE only)
//   i_start, o_busy        batch start, RUN/DRAIN indicator
//   o_finished             one-cycle pulse at batch end
//   i_vertex*              input stream (valid/ready, last, midx)
//   o_vertex*              output stream (valid/ready, last)
//   o_count, o_sat         batch vertex count, sticky saturation flag
module vertex_transform_unit #(
    parameter int DATAWIDTH  = 24,
    parameter int FRACBITS   = 13,
    parameter int NUM_MATS   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MIDX_W     = (NUM_MATS > 1) ? $clog2(NUM_MATS) : 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_mat_wr,
    input  logic [MIDX_W-1:0]             i_mat_idx,
    input  logic [3:0][3:0][DATAWIDTH-1:0] i_mat,
    input  logic                          i_start,
    output logic                          o_busy,
    output logic                          o_finished,
    input  logic [2:0][DATAWIDTH-1:0]     i_vertex,
    input  logic [MIDX_W-1:0]             i_vertex_midx,
    input  logic                          i_vertex_valid,
    input  logic                          i_vertex_last,
    output logic                          o_vertex_ready,
    output logic [3:0][DATAWIDTH-1:0]     o_vertex,
    output logic                          o_vertex_valid,
    output logic                          o_vertex_last,
    input  logic                          i_vertex_ready,
    output logic [15:0]                   o_count,
    output logic                          o_sat
);

    localparam int PW    = 2 * DATAWIDTH;
    localparam int SW    = PW + 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [DATAWIDTH-1:0] ONE =
        DATAWIDTH'(64'd1 << FRACBITS);
    localparam logic signed [SW-1:0] MAXV =
        {{(SW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
    // Two's complement: ~max is the most negative DATAWIDTH value.
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    function automatic logic signed [PW-1:0] mul(
        input logic signed [DATAWIDTH-1:0] a,
        input logic signed [DATAWIDTH-1:0] b
    );
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] eb;
        ea = PW'(a);
        eb = PW'(b);
        return ea * eb;
    endfunction

    logic [1:0]           state;
    logic [DATAWIDTH-1:0] bank [NUM_MATS][4][4];

    logic                 s1_valid, s1_last;
    logic signed [PW-1:0] prod [4][4];
    logic                 s2_valid, s2_last;
    logic signed [SW-1:0] sum [4];
    logic                 s3_valid, s3_last;
    logic [3:0][DATAWIDTH-1:0] s3_data;

    logic [4*DATAWIDTH:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     fifo_count;

    logic                 accept, push, pop, pipe_empty;
    logic [1:0]           inflight;
    logic [MIDX_W-1:0]    sel;
    logic [DATAWIDTH-1:0] vin [4];
    logic signed [SW-1:0] sh [4];
    logic [3:0][DATAWIDTH-1:0] res;
    logic [3:0]           clamp;

    always_comb begin
        inflight = 2'(s1_valid) + 2'(s2_valid) + 2'(s3_valid);
        pipe_empty = !(s1_valid || s2_valid || s3_valid);
        // Credits cover every vertex that will land in the FIFO,
        // so the pipeline itself never needs to stall.
        o_vertex_ready = (state == RUN) &&
            (int'(fifo_count) + int'(inflight) < FIFO_DEPTH);
        accept = i_vertex_valid && o_vertex_ready;
        o_vertex_valid = (fifo_count != '0);
        push = s3_valid;
        pop = o_vertex_valid && i_vertex_ready;
        o_busy = (state == RUN) || (state == DRAIN);
        o_finished = (state == DONE);
        sel = (int'(i_vertex_midx) < NUM_MATS) ? i_vertex_midx : '0;
        vin[0] = i_vertex[0];
        vin[1] = i_vertex[1];
        vin[2] = i_vertex[2];
        vin[3] = ONE;
    end

    assign {o_vertex_last, o_vertex} =
        o_vertex_valid ? mem[rd_ptr] : '0;

    always_comb begin
        res = '0;
        clamp = '0;
        for (int r = 0; r < 4; r++) begin
            sh[r] = sum[r] >>> FRACBITS;
            if (sh[r] > MAXV) begin
                res[r] = MAXV[DATAWIDTH-1:0];
                clamp[r] = 1'b1;
            end else if (sh[r] < MINV) begin
                res[r] = MINV[DATAWIDTH-1:0];
                clamp[r] = 1'b1;
            end else begin
                res[r] = sh[r][DATAWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            o_count <= '0;
            o_sat <= 1'b0;
        end else begin
            unique case (state)
                IDLE:  if (i_start) state <= RUN;
                RUN:   if (accept && i_vertex_last) state <= DRAIN;
                DRAIN: if (pipe_empty && !o_vertex_valid) state <= DONE;
                DONE:  state <= IDLE;
            endcase
            if (state == IDLE && i_start) begin
                o_count <= '0;
                o_sat <= 1'b0;
            end else begin
                if (accept) o_count <= o_count + 16'd1;
                if (s2_valid && |clamp) o_sat <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int m = 0; m < NUM_MATS; m++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        bank[m][r][c] <= '0;
        end else if (state == IDLE && i_mat_wr &&
                     int'(i_mat_idx) < NUM_MATS) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    bank[i_mat_idx][r][c] <= i_mat[r][c];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_last <= 1'b0;
            s2_valid <= 1'b0;
            s2_last <= 1'b0;
            s3_valid <= 1'b0;
            s3_last <= 1'b0;
            s3_data <= '0;
            for (int r = 0; r < 4; r++) begin
                sum[r] <= '0;
                for (int c = 0; c < 4; c++) prod[r][c] <= '0;
            end
        end else begin
            s1_valid <= accept;
            s1_last <= i_vertex_last;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    prod[r][c] <= mul(bank[sel][r][c], vin[c]);
            s2_valid <= s1_valid;
            s2_last <= s1_last;
            for (int r = 0; r < 4; r++)
                sum[r] <= SW'(prod[r][0]) + SW'(prod[r][1]) +
                          SW'(prod[r][2]) + SW'(prod[r][3]);
            s3_valid <= s2_valid;
            s3_last <= s2_last;
            s3_data <= res;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s3_last, s3_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ?
                          '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ?
                          '0 : rd_ptr + 1'b1;
            if (push && !pop) fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_vertex_transform_unit.sv
// Scoreboard bench for vertex_transform_unit.
// Reference model uses plain longint matrix arithmetic.
module tb_vertex_transform_unit;

    localparam int DW = 24;
    localparam int FB = 13;
    localparam int NM = 4;
    localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (DW - 1));

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic i_mat_wr = 1'b0;
    logic [1:0] i_mat_idx = '0;
    logic [3:0][3:0][DW-1:0] i_mat = '0;
    logic i_start = 1'b0;
    logic o_busy, o_finished;
    logic [2:0][DW-1:0] i_vertex = '0;
    logic [1:0] i_vertex_midx = '0;
    logic i_vertex_valid = 1'b0;
    logic i_vertex_last = 1'b0;
    logic o_vertex_ready;
    logic [3:0][DW-1:0] o_vertex;
    logic o_vertex_valid, o_vertex_last;
    logic i_vertex_ready = 1'b0;
    logic [15:0] o_count;
    logic o_sat;

    vertex_transform_unit dut (
        .clk(clk), .rstn(rstn),
        .i_mat_wr(i_mat_wr), .i_mat_idx(i_mat_idx), .i_mat(i_mat),
        .i_start(i_start), .o_busy(o_busy), .o_finished(o_finished),
        .i_vertex(i_vertex), .i_vertex_midx(i_vertex_midx),
        .i_vertex_valid(i_vertex_valid),
        .i_vertex_last(i_vertex_last),
        .o_vertex_ready(o_vertex_ready), .o_vertex(o_vertex),
        .o_vertex_valid(o_vertex_valid),
        .o_vertex_last(o_vertex_last),
        .i_vertex_ready(i_vertex_ready),
        .o_count(o_count), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][DW-1:0] v;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int rdy_mode = 1;
    int last_cnt = 0;
    longint mb[NM][4][4];
    bit sat_exp = 0;
    int cnt_exp = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Downstream ready: 0 hold low, 1 hold high, else random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: i_vertex_ready = 1'b0;
            1: i_vertex_ready = 1'b1;
            default: i_vertex_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (rstn && o_vertex_valid && i_vertex_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                for (int r = 0; r < 4; r++)
                    chk($sformatf("out_c%0d", r),
                        longint'($signed(o_vertex[r])),
                        longint'($signed(e.v[r])));
                chk("out_last", longint'(o_vertex_last),
                    longint'(e.last));
                if (e.last) last_cnt++;
            end
        end
    end

    task automatic push_exp(input logic [2:0][DW-1:0] v,
                            input int midx, input logic last);
        longint vv[4];
        longint acc, q;
        exp_t e;
        int m;
        m = (midx < NM) ? midx : 0;
        for (int i = 0; i < 3; i++) vv[i] = longint'($signed(v[i]));
        vv[3] = longint'(1) << FB;
        for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int c = 0; c < 4; c++) acc += mb[m][r][c] * vv[c];
            q = acc >>> FB;
            if (q > MAXV) begin
                q = MAXV;
                sat_exp = 1;
            end else if (q < MINV) begin
                q = MINV;
                sat_exp = 1;
            end
            e.v[r] = q[DW-1:0];
        end
        e.last = last;
        exp_q.push_back(e);
        cnt_exp++;
    endtask

    task automatic write_mat(input int idx,
                             input logic [3:0][3:0][DW-1:0] m,
                             input bit legal);
        i_mat_wr = 1'b1;
        i_mat_idx = 2'(idx);
        i_mat = m;
        @(posedge clk);
        #1 i_mat_wr = 1'b0;
        if (legal)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    mb[idx][r][c] = longint'($signed(m[r][c]));
    endtask

    task automatic start_batch();
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        sat_exp = 0;
        cnt_exp = 0;
        chk("start_busy", longint'(o_busy), 1);
        chk("start_count", longint'(o_count), 0);
        chk("start_sat", longint'(o_sat), 0);
    endtask

    task automatic send(input logic [2:0][DW-1:0] v, input int midx,
                        input logic last);
        int n;
        n = 0;
        i_vertex = v;
        i_vertex_midx = 2'(midx);
        i_vertex_last = last;
        i_vertex_valid = 1'b1;
        @(negedge clk);
        while (!o_vertex_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("send_timeout", n, 0);
        end else begin
            @(posedge clk);
            push_exp(v, midx, last);
        end
        #1 i_vertex_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (last_cnt == base && n < 2000);
        chk("last_seen", longint'(last_cnt != base), 1);
        @(negedge clk);
        chk("drain_finished", longint'(o_finished), 0);
        chk("drain_busy", longint'(o_busy), 1);
        @(negedge clk);
        chk("done_finished", longint'(o_finished), 1);
        chk("done_busy", longint'(o_busy), 0);
        chk("done_count", longint'(o_count), longint'(cnt_exp));
        chk("done_sat", longint'(o_sat), longint'(sat_exp));
        @(negedge clk);
        chk("idle_finished", longint'(o_finished), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd(input int range);
        int x;
        x = int'($urandom_range(0, 2 * range)) - range;
        return DW'(x);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, longint'(o_busy), 0);
        chk({tag, "_fin"}, longint'(o_finished), 0);
        chk({tag, "_ready"}, longint'(o_vertex_ready), 0);
        chk({tag, "_valid"}, longint'(o_vertex_valid), 0);
        chk({tag, "_last"}, longint'(o_vertex_last), 0);
        chk({tag, "_vertex"}, longint'(o_vertex != '0), 0);
        chk({tag, "_count"}, longint'(o_count), 0);
        chk({tag, "_sat"}, longint'(o_sat), 0);
    endtask

    initial begin
        logic [3:0][3:0][DW-1:0] m;
        logic [2:0][DW-1:0] v;
        int base;
        int midx;
        for (int a = 0; a < NM; a++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) mb[a][r][c] = 0;

        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1 chk_reset_outputs("idle");

        m = '0;
        for (int i = 0; i < 4; i++) m[i][i] = DW'(8192);
        write_mat(0, m, 1);
        m[0][3] = DW'(8192);
        m[1][3] = DW'(-16384);
        write_mat(1, m, 1);
        m = '0;
        for (int i = 0; i < 3; i++) m[i][i] = DW'(512 * 8192);
        m[3][3] = DW'(8192);
        write_mat(2, m, 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) m[r][c] = rnd(16384);
        write_mat(3, m, 1);

        // Identity with latency check.
        rdy_mode = 1;
        start_batch();
        base = last_cnt;
        v[0] = DW'(8192);
        v[1] = DW'(16384);
        v[2] = DW'(24576);
        send(v, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i >= 2)
                chk($sformatf("latency_%0d", i),
                    longint'(o_vertex_valid), longint'(i == 3));
        end
        wait_done(base);

        // Alternating matrix select, illegal write/start mid-batch.
        start_batch();
        base = last_cnt;
        for (int i = 0; i < 6; i++) begin
            send('0, i % 2, 1'(i == 5));
            if (i == 2) begin
                i_start = 1'b1;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) m[r][c] = DW'(8388607);
                write_mat(0, m, 0);
                i_start = 1'b0;
                chk("illegal_busy", longint'(o_busy), 1);
                chk("illegal_count", longint'(o_count), 3);
            end
        end
        wait_done(base);

        // Saturation; flag sticks into IDLE.
        start_batch();
        base = last_cnt;
        v[0] = DW'(32768);
        v[1] = DW'(-32768);
        v[2] = '0;
        send(v, 2, 1'b1);
        wait_done(base);
        repeat (3) @(posedge clk);
        #1 chk("sat_sticky", longint'(o_sat), 1);

        // Backpressure: fill credits, then random downstream.
        rdy_mode = 0;
        start_batch();
        base = last_cnt;
        for (int i = 0; i < 8; i++) begin
            v[0] = rnd(1 << 18);
            v[1] = rnd(1 << 18);
            v[2] = rnd(1 << 18);
            send(v, $urandom_range(0, 3), 1'b0);
        end
        @(negedge clk);
        chk("credit_full", longint'(o_vertex_ready), 0);
        repeat (4) @(negedge clk);
        chk("credit_hold", longint'(o_vertex_ready), 0);
        @(posedge clk);
        #1 rdy_mode = 2;
        for (int i = 8; i < 20; i++) begin
            v[0] = rnd(1 << 18);
            v[1] = rnd(1 << 18);
            v[2] = rnd(1 << 18);
            midx = $urandom_range(0, 3);
            send(v, midx, 1'(i == 19));
        end
        wait_done(base);
        chk("bp_count", longint'(cnt_exp), 20);

        // Mid-batch reset with vertices in flight.
        rdy_mode = 0;
        start_batch();
        for (int i = 0; i < 3; i++) send(v, 0, 1'b0);
        #3 rstn = 1'b0;
        #1 chk_reset_outputs("midrst");
        exp_q.delete();
        for (int a = 0; a < NM; a++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) mb[a][r][c] = 0;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1 chk_reset_outputs("postrst");
        rdy_mode = 1;
        start_batch();
        base = last_cnt;
        v[0] = DW'(8192);
        v[1] = DW'(8192);
        v[2] = DW'(8192);
        send(v, 1, 1'b1);
        wait_done(base);

        chk("queue_empty", longint'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
